// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler: latches pending calls and issues them one at a time to the lift FSM
// in collective-sweep ring order (1U,2U,3U,4D,3D,2D), clearing each when the lift reports done.
module lift_call_scheduler #(
  parameter int TW           = 8,
  parameter int DONE_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [2:0] call_code,
  output logic       req_valid,
  output logic [2:0] req_code,
  input  logic       req_ready,
  input  logic       done,
  output logic [5:0] pending,
  output logic       busy,
  output logic       call_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  // Call code -> pending bit; zero for the two invalid codes.
  function automatic logic [5:0] code_onehot(input logic [2:0] code);
    case (code)
      3'b001:  return 6'b000001;
      3'b010:  return 6'b000010;
      3'b011:  return 6'b000100;
      3'b110:  return 6'b001000;
      3'b111:  return 6'b010000;
      3'b100:  return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] pos_code(input logic [2:0] pos);
    case (pos)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      3'd2:    return 3'b011;
      3'd3:    return 3'b100;
      3'd4:    return 3'b111;
      3'd5:    return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] code_pos(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd0;
      3'b010:  return 3'd1;
      3'b011:  return 3'd2;
      3'b100:  return 3'd3;
      3'b111:  return 3'd4;
      3'b110:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [2:0]    req_code_q, req_code_d;
  logic [5:0]    pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          call_err_q, call_err_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ptr_q, ptr_d;
  logic          sel_found_s;
  logic [2:0]    sel_pos_s;

  // Ring search: first pending call strictly after ptr, ptr's own position tested last.
  always_comb begin : ring_select
    logic [2:0] pos;
    sel_found_s = 1'b0;
    sel_pos_s   = 3'd0;
    pos         = ptr_q;
    for (int k = 0; k < 6; k++) begin
      pos = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
      if (!sel_found_s && ((pending_q & code_onehot(pos_code(pos))) != 6'b000000)) begin
        sel_found_s = 1'b1;
        sel_pos_s   = pos;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state logic for the FSM, pending register and pulse outputs.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_code_d  = req_code_q;
    timer_d     = timer_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    call_err_d  = call_valid && (code_onehot(call_code) == 6'b000000);
    pending_d   = call_valid ? (pending_q | code_onehot(call_code)) : pending_q;

    case (state_q)
      S_IDLE: begin
        if (sel_found_s) begin
          req_code_d  = pos_code(sel_pos_s);
          req_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_CLEAR;
        end else if (timer_q == TIMER_LAST) begin
          // Abandon: pending bit and ptr stay, so the same call is picked again.
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_CLEAR: begin
        // Clearing after the OR absorbs a repeat call for the served button.
        pending_d = pending_d & ~code_onehot(req_code_q);
        ptr_d     = code_pos(req_code_q);
        state_d   = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_code_q  <= 3'b000;
      pending_q   <= 6'b000000;
      busy_q      <= 1'b0;
      call_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
      ptr_q       <= 3'd5;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_code_q  <= req_code_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      call_err_q  <= call_err_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      ptr_q       <= ptr_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_code  = req_code_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign call_err  = call_err_q;
  assign timeout   = timeout_q;

endmodule
